// File: rtl/cpu_pkg.sv
// Shared definitions for the RAM bus arbiter: bus width defaults, owner codes
// and the arbiter state encoding.
package cpu_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] OWN_LD   = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_MON  = 2'd2;
    localparam logic [1:0] OWN_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;
endpackage

// File: rtl/arb_timer.sv
// Grant-length counter: cleared on grant entry, counts GRANT cycles (saturating),
// and flags expiry on the edge that would complete the TIMEOUT-th grant cycle.
module arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic step_clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expire
);
    logic [7:0] count_reg;

    always_ff @(posedge step_clk or negedge reset) begin
        if (!reset) begin
            count_reg <= 8'd0;
        end else if (start) begin
            count_reg <= 8'd0;
        end else if (run && count_reg != 8'hFF) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    // count_reg holds completed GRANT cycles, so +1 includes the one ending now
    assign expire = run && (({1'b0, count_reg} + 9'd1) >= 9'(TIMEOUT));
endmodule

// File: rtl/ram_bus_arbiter.sv
// Three-way RAM bus arbiter: loader has absolute priority, CPU and monitor share
// round-robin; grants are timed out, and a timed-out requester is masked until it drops.
module ram_bus_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              step_clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] mon_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic [DATA_W-1:0] mon_data,
    input  logic              ld_set_addr,
    input  logic              cpu_set_addr,
    input  logic              mon_set_addr,
    input  logic              ld_set_ram,
    input  logic              cpu_set_ram,
    input  logic              mon_set_ram,
    output logic [2:0]        gnt,
    output logic [1:0]        owner,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_set_addr,
    output logic              ram_set_ram,
    output logic              busy,
    output logic              timeout_err
);
    state_t     state_reg, state_next;
    logic [2:0] gnt_reg, gnt_next;
    logic [1:0] owner_reg, owner_next;
    logic       busy_reg, busy_next;
    logic       err_reg, err_next;
    logic [2:0] mask_reg, mask_next;
    logic       ptr_reg, ptr_next;   // 0: CPU wins a tie, 1: monitor wins
    logic       start;
    logic       expire;
    logic [2:0] eligible;

    assign eligible = req & ~mask_reg;

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .step_clk (step_clk),
        .reset    (reset),
        .start    (start),
        .run      (state_reg == ST_GRANT),
        .expire   (expire)
    );

    always_ff @(posedge step_clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= 3'b000;
            owner_reg <= OWN_NONE;
            busy_reg  <= 1'b0;
            err_reg   <= 1'b0;
            mask_reg  <= 3'b000;
            ptr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            owner_reg <= owner_next;
            busy_reg  <= busy_next;
            err_reg   <= err_next;
            mask_reg  <= mask_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        owner_next = owner_reg;
        err_next   = err_reg;
        ptr_next   = ptr_reg;
        start      = 1'b0;
        // a masked requester is released as soon as its req is seen low
        mask_next  = mask_reg & req;
        case (state_reg)
            ST_IDLE: begin
                if (eligible != 3'b000) begin
                    state_next = ST_GRANT;
                    start      = 1'b1;
                    if (eligible[0]) begin
                        gnt_next   = 3'b001;
                        owner_next = OWN_LD;
                    end else if (eligible[1] && (!eligible[2] || !ptr_reg)) begin
                        gnt_next   = 3'b010;
                        owner_next = OWN_CPU;
                        ptr_next   = 1'b1;
                    end else begin
                        gnt_next   = 3'b100;
                        owner_next = OWN_MON;
                        ptr_next   = 1'b0;
                    end
                end
            end
            ST_GRANT: begin
                if ((req & gnt_reg) == 3'b000) begin
                    state_next = ST_TURN;
                    gnt_next   = 3'b000;
                    owner_next = OWN_NONE;
                end else if (expire) begin
                    state_next = ST_TURN;
                    gnt_next   = 3'b000;
                    owner_next = OWN_NONE;
                    err_next   = 1'b1;
                    mask_next  = (mask_reg & req) | gnt_reg;
                end
            end
            ST_TURN: state_next = ST_IDLE;
            default: begin
                state_next = ST_IDLE;
                gnt_next   = 3'b000;
                owner_next = OWN_NONE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    always_comb begin
        ram_addr     = '0;
        ram_data     = '0;
        ram_set_addr = 1'b0;
        ram_set_ram  = 1'b0;
        if (state_reg == ST_GRANT) begin
            case (owner_reg)
                OWN_LD: begin
                    ram_addr = ld_addr;  ram_data = ld_data;
                    ram_set_addr = ld_set_addr;  ram_set_ram = ld_set_ram;
                end
                OWN_CPU: begin
                    ram_addr = cpu_addr;  ram_data = cpu_data;
                    ram_set_addr = cpu_set_addr;  ram_set_ram = cpu_set_ram;
                end
                OWN_MON: begin
                    ram_addr = mon_addr;  ram_data = mon_data;
                    ram_set_addr = mon_set_addr;  ram_set_ram = mon_set_ram;
                end
                default: ;
            endcase
        end
    end

    assign gnt         = gnt_reg;
    assign owner       = owner_reg;
    assign busy        = busy_reg;
    assign timeout_err = err_reg;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter (TIMEOUT=4): reset, priority, round-robin,
// strobe gating, async reset and timeout masking, with hand-computed expectations.
module tb_ram_bus_arbiter;
    logic       step_clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] req = 3'b000;
    logic [7:0] ld_addr = 8'h00, cpu_addr = 8'h00, mon_addr = 8'h00;
    logic [7:0] ld_data = 8'h00, cpu_data = 8'h00, mon_data = 8'h00;
    logic       ld_set_addr = 1'b0, cpu_set_addr = 1'b0, mon_set_addr = 1'b0;
    logic       ld_set_ram = 1'b0, cpu_set_ram = 1'b0, mon_set_ram = 1'b0;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic [7:0] ram_addr, ram_data;
    logic       ram_set_addr, ram_set_ram, busy, timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    ram_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
        .step_clk(step_clk), .reset(reset), .req(req),
        .ld_addr(ld_addr), .cpu_addr(cpu_addr), .mon_addr(mon_addr),
        .ld_data(ld_data), .cpu_data(cpu_data), .mon_data(mon_data),
        .ld_set_addr(ld_set_addr), .cpu_set_addr(cpu_set_addr), .mon_set_addr(mon_set_addr),
        .ld_set_ram(ld_set_ram), .cpu_set_ram(cpu_set_ram), .mon_set_ram(mon_set_ram),
        .gnt(gnt), .owner(owner), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_set_addr(ram_set_addr), .ram_set_ram(ram_set_ram),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 step_clk = ~step_clk;

    task automatic tick();
        @(posedge step_clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;   // no clock edge has occurred yet: checks are purely asynchronous
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt: got %b want 000", gnt); end
        n_cmp++; if (owner !== 2'd3) begin n_err++; $display("FAIL rst_owner: got %0d want 3", owner); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", timeout_err); end
        n_cmp++; if (ram_addr !== 8'h00 || ram_set_ram !== 1'b0 || ram_set_addr !== 1'b0) begin
            n_err++; $display("FAIL rst_ram: got addr %h set_ram %b set_addr %b want 00 0 0", ram_addr, ram_set_ram, ram_set_addr);
        end
        req = 3'b111;
        tick(); tick();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_hold_gnt: got %b want 000", gnt); end
        req = 3'b000;
        reset = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_loader_grant();
        req = 3'b001; ld_addr = 8'h05; ld_data = 8'hA5; ld_set_ram = 1'b1;
        cpu_addr = 8'h77; cpu_data = 8'h66;
        tick();
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL ld_gnt: got %b want 001", gnt); end
        n_cmp++; if (owner !== 2'd0) begin n_err++; $display("FAIL ld_owner: got %0d want 0", owner); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ld_busy: got %b want 1", busy); end
        n_cmp++; if (ram_addr !== 8'h05 || ram_data !== 8'hA5) begin
            n_err++; $display("FAIL ld_bus: got %h/%h want 05/a5", ram_addr, ram_data);
        end
        n_cmp++; if (ram_set_ram !== 1'b1) begin n_err++; $display("FAIL ld_set_ram: got %b want 1", ram_set_ram); end
        // non-owner strobes must not leak through
        ld_set_ram = 1'b0; cpu_set_ram = 1'b1; cpu_set_addr = 1'b1;
        #1;
        n_cmp++; if (ram_set_ram !== 1'b0) begin n_err++; $display("FAIL nonowner_set_ram: got %b want 0", ram_set_ram); end
        n_cmp++; if (ram_set_addr !== 1'b0) begin n_err++; $display("FAIL nonowner_set_addr: got %b want 0", ram_set_addr); end
        ld_set_ram = 1'b1; ld_addr = 8'h06;
        #1;
        n_cmp++; if (ram_set_ram !== 1'b1 || ram_addr !== 8'h06) begin
            n_err++; $display("FAIL ld_track: got set_ram %b addr %h want 1 06", ram_set_ram, ram_addr);
        end
        req = 3'b000;
        tick();
        n_cmp++; if (gnt !== 3'b000 || owner !== 2'd3 || busy !== 1'b1) begin
            n_err++; $display("FAIL ld_turn: got gnt %b owner %0d busy %b want 000 3 1", gnt, owner, busy);
        end
        n_cmp++; if (ram_set_ram !== 1'b0 || ram_addr !== 8'h00) begin
            n_err++; $display("FAIL turn_ram: got set_ram %b addr %h want 0 00", ram_set_ram, ram_addr);
        end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ld_idle_busy: got %b want 0", busy); end
        ld_set_ram = 1'b0; cpu_set_ram = 1'b0; cpu_set_addr = 1'b0;
        $display("test_loader_grant done");
    endtask

    task automatic test_round_robin();
        req = 3'b110;
        tick();
        n_cmp++; if (gnt !== 3'b010 || owner !== 2'd1) begin
            n_err++; $display("FAIL rr_cpu1: got gnt %b owner %0d want 010 1", gnt, owner);
        end
        n_cmp++; if (ram_addr !== 8'h77) begin n_err++; $display("FAIL rr_cpu_addr: got %h want 77", ram_addr); end
        tick(); tick();
        req = 3'b100;
        tick();
        n_cmp++; if (gnt !== 3'b000 || busy !== 1'b1) begin
            n_err++; $display("FAIL rr_turn1: got gnt %b busy %b want 000 1", gnt, busy);
        end
        req = 3'b110;
        tick();
        n_cmp++; if (gnt !== 3'b000 || busy !== 1'b0) begin
            n_err++; $display("FAIL rr_idle1: got gnt %b busy %b want 000 0", gnt, busy);
        end
        tick();
        n_cmp++; if (gnt !== 3'b100 || owner !== 2'd2) begin
            n_err++; $display("FAIL rr_mon: got gnt %b owner %0d want 100 2", gnt, owner);
        end
        tick(); tick();
        req = 3'b010;
        tick();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rr_turn2: got %b want 000", gnt); end
        req = 3'b110;
        tick();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rr_idle2: got %b want 000", gnt); end
        tick();
        n_cmp++; if (gnt !== 3'b010 || owner !== 2'd1) begin
            n_err++; $display("FAIL rr_cpu2: got gnt %b owner %0d want 010 1", gnt, owner);
        end
        req = 3'b000;
        tick(); tick();
        $display("test_round_robin done");
    endtask

    task automatic test_no_preempt();
        req = 3'b010;
        tick();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL np_cpu: got %b want 010", gnt); end
        req = 3'b011;
        tick();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL np_keep: got %b want 010", gnt); end
        req = 3'b001;
        tick();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL np_turn: got %b want 000", gnt); end
        tick();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL np_idle: got %b want 000", gnt); end
        tick();
        n_cmp++; if (gnt !== 3'b001 || owner !== 2'd0) begin
            n_err++; $display("FAIL np_ld: got gnt %b owner %0d want 001 0", gnt, owner);
        end
        req = 3'b000;
        tick(); tick();
        $display("test_no_preempt done");
    endtask

    task automatic test_async_reset();
        req = 3'b001; ld_set_ram = 1'b1;
        tick();
        n_cmp++; if (gnt !== 3'b001 || ram_set_ram !== 1'b1) begin
            n_err++; $display("FAIL ar_pre: got gnt %b set_ram %b want 001 1", gnt, ram_set_ram);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (gnt !== 3'b000 || busy !== 1'b0 || ram_set_ram !== 1'b0) begin
            n_err++; $display("FAIL ar_drop: got gnt %b busy %b set_ram %b want 000 0 0", gnt, busy, ram_set_ram);
        end
        n_cmp++; if (owner !== 2'd3 || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL ar_owner_err: got owner %0d err %b want 3 0", owner, timeout_err);
        end
        #2 reset = 1'b1;
        tick();
        n_cmp++; if (gnt !== 3'b001) begin n_err++; $display("FAIL ar_regrant: got %b want 001", gnt); end
        req = 3'b000; ld_set_ram = 1'b0;
        tick(); tick();
        $display("test_async_reset done");
    endtask

    task automatic test_timeout();
        req = 3'b010;
        tick();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL to_grant: got %b want 010", gnt); end
        tick(); tick(); tick();
        n_cmp++; if (gnt !== 3'b010 || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL to_cycle4: got gnt %b err %b want 010 0", gnt, timeout_err);
        end
        tick();
        n_cmp++; if (gnt !== 3'b000 || timeout_err !== 1'b1 || owner !== 2'd3) begin
            n_err++; $display("FAIL to_expire: got gnt %b err %b owner %0d want 000 1 3", gnt, timeout_err, owner);
        end
        req = 3'b110;
        tick();
        n_cmp++; if (gnt !== 3'b000) begin n_err++; $display("FAIL to_idle: got %b want 000", gnt); end
        tick();
        n_cmp++; if (gnt !== 3'b100) begin n_err++; $display("FAIL to_mon: got %b want 100", gnt); end
        req = 3'b010;
        tick(); tick(); tick();
        n_cmp++; if (gnt !== 3'b000 || busy !== 1'b0) begin
            n_err++; $display("FAIL to_masked: got gnt %b busy %b want 000 0", gnt, busy);
        end
        req = 3'b000;
        tick();
        req = 3'b010;
        tick();
        n_cmp++; if (gnt !== 3'b010) begin n_err++; $display("FAIL to_unmask: got %b want 010", gnt); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
        req = 3'b000;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", timeout_err); end
        #2 reset = 1'b1;
        tick();
        $display("test_timeout done");
    endtask

    initial begin
        test_reset();
        test_loader_grant();
        test_round_robin();
        test_no_preempt();
        test_async_reset();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
